// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake and a global stall.
// Define KS_OVERFLOW_EN to add the registered signed-overflow output Ovf.
module kogge_stone_pipe #(
    parameter int WIDTH            = 16,
    parameter int LEVELS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
`ifdef KS_OVERFLOW_EN
    output logic             Ovf,
`endif
    output logic             Cout
);
    localparam int NLEV = $clog2(WIDTH);
    localparam int NSTG = (NLEV + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

    typedef struct packed {
        logic [WIDTH-1:0] g;   // group generate, bit 0 already includes the carry-in
        logic [WIDTH-1:0] p;   // group propagate
        logic [WIDTH-1:0] po;  // original bitwise propagate, needed for the final XOR
        logic             c0;
    } pfx_t;

    pfx_t             stg_q [NSTG];
    pfx_t             stg_d [NSTG];
    logic [NSTG:0]    vld_q, vld_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef KS_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif
    logic             advance;

    // Applies the prefix levels owned by pipeline stage s.
    function automatic pfx_t levels(input pfx_t x, input int s);
        pfx_t             y;
        logic [WIDTH-1:0] g0, p0;
        int               d;
        y = x;
        for (int k = 0; k < NLEV; k++) begin
            if (k / LEVELS_PER_STAGE == s) begin
                g0 = y.g;
                p0 = y.p;
                d  = 1 << k;
                for (int i = 0; i < WIDTH; i++) begin
                    if (i >= d) begin
                        y.g[i] = g0[i] | (p0[i] & g0[i-d]);
                        y.p[i] = p0[i] & p0[i-d];
                    end
                end
            end
        end
        return y;
    endfunction

    assign advance   = !vld_q[NSTG] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[NSTG];
    assign Sum       = sum_q;
    assign Cout      = cout_q;
`ifdef KS_OVERFLOW_EN
    assign Ovf       = ovf_q;
`endif

    always_comb begin
        logic [WIDTH-1:0] bx, pi, gi, carries;
        logic             c0;
        pfx_t             fin;
        stg_d   = stg_q;
        vld_d   = vld_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef KS_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        bx      = B ^ {WIDTH{Sub}};
        c0      = Cin ^ Sub;
        pi      = A ^ bx;
        gi      = A & bx;
        gi[0]   = gi[0] | (pi[0] & c0);
        fin     = levels(stg_q[NSTG-1], NSTG - 1);
        carries = {fin.g[WIDTH-2:0], fin.c0};
        if (advance) begin
            vld_d = {vld_q[NSTG-1:0], in_valid};
            // Data registers only load behind a valid beat so X operands never reach Sum.
            if (in_valid) begin
                stg_d[0].g  = gi;
                stg_d[0].p  = pi;
                stg_d[0].po = pi;
                stg_d[0].c0 = c0;
            end
            for (int s = 0; s < NSTG - 1; s++) begin
                if (vld_q[s]) stg_d[s+1] = levels(stg_q[s], s);
            end
            if (vld_q[NSTG-1]) begin
                sum_d  = fin.po ^ carries;
                cout_d = fin.g[WIDTH-1];
`ifdef KS_OVERFLOW_EN
                ovf_d  = carries[WIDTH-1] ^ fin.g[WIDTH-1];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef KS_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
            for (int s = 0; s < NSTG; s++) stg_q[s] <= '0;
        end else begin
            vld_q  <= vld_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
`ifdef KS_OVERFLOW_EN
            ovf_q  <= ovf_d;
`endif
            for (int s = 0; s < NSTG; s++) stg_q[s] <= stg_d[s];
        end
    end
endmodule
